// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: synthesizable pass/fail/timeout checker for riscv-tests.
// Snoops register-file writes to x3, x28 and x29 and reports sticky status.
//
// Ports:
//   clk       in   core clock
//   rst       in   synchronous active-high reset
//   rf_wen    in   register-file write enable
//   rf_waddr  in   [4:0]  register-file write address
//   rf_wdata  in   [31:0] register-file write data
//   done      out  terminal state reached (pass, fail or timeout)
//   pass      out  test passed
//   fail      out  test failed
//   timeout   out  test timed out
//   test_num  out  [31:0] last value written to x3
//   cycles    out  [CNT_W-1:0] cycles spent in RUN, frozen once terminal
module riscv_test_monitor #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rf_wen,
    input  logic [4:0]       rf_waddr,
    input  logic [31:0]      rf_wdata,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [31:0]      test_num,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST =
        CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic              r_done;
    logic              r_pass;
    logic              r_fail;
    logic              r_timeout;
    logic [31:0]       r_test_num;
    logic [CNT_W-1:0]  r_cycles;
    logic [31:0]       r_x29;
    logic              r_x29_valid;

    logic              w_wr3;
    logic              w_wr29;
    logic              w_trig;
    logic              w_sig_ok;

    // x0 never matches 3, 28 or 29, so it is ignored implicitly.
    assign w_wr3    = rf_wen && (rf_waddr == 5'd3);
    assign w_wr29   = rf_wen && (rf_waddr == 5'd29);
    assign w_trig   = rf_wen && (rf_waddr == 5'd28)
                      && (rf_wdata == 32'd1);
    assign w_sig_ok = r_x29_valid && (r_x29 == 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_test_num  <= 32'd0;
            r_cycles    <= '0;
            r_x29       <= 32'd0;
            r_x29_valid <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // The transition edge is counted too, so a
                    // timeout leaves cycles at TIMEOUT_CYCLES.
                    r_cycles <= r_cycles + 1'b1;
                    if (w_wr3) begin
                        r_test_num <= rf_wdata;
                    end
                    if (w_wr29) begin
                        r_x29       <= rf_wdata;
                        r_x29_valid <= 1'b1;
                    end
                    // Trigger takes priority over a same-cycle timeout.
                    if (w_trig) begin
                        r_done <= 1'b1;
                        if (w_sig_ok) begin
                            r_state <= S_PASS;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end else if (r_cycles == LP_LAST) begin
                        r_state   <= S_TIMEOUT;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign done     = r_done;
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign timeout  = r_timeout;
    assign test_num = r_test_num;
    assign cycles   = r_cycles;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: directed self-checking bench for riscv_test_monitor.
// Runs pass, fail, guard, timeout and reset scenarios with TIMEOUT_CYCLES=50.
module tb_riscv_test_monitor;

    localparam int TO = 50;
    localparam int CW = 32;

    logic          clk;
    logic          rst;
    logic          rf_wen;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          done;
    logic          pass;
    logic          fail;
    logic          timeout;
    logic [31:0]   test_num;
    logic [CW-1:0] cycles;

    int n_tests;
    int n_fail;

    riscv_test_monitor #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W         (CW)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .rf_wen  (rf_wen),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .done    (done),
        .pass    (pass),
        .fail    (fail),
        .timeout (timeout),
        .test_num(test_num),
        .cycles  (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Status packed as {done, pass, fail, timeout}.
    function automatic logic [31:0] st();
        return {28'd0, done, pass, fail, timeout};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rf_wen   = 1'b1;
        rf_waddr = a;
        rf_wdata = d;
        @(negedge clk);
        rf_wen   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cnt(input int v);
        for (int i = 0; i < 200; i++) begin
            if (cycles == CW'(v)) break;
            @(negedge clk);
        end
        check("wait_cnt", cycles, v);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        rf_wen   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_status", st(), 32'h0);
        check("rst_tnum", test_num, 32'd0);
        check("rst_cyc", cycles, 32'd0);

        // Pass: trigger sampled while cycles==20.
        wr(5'd3, 32'd5);
        wr(5'd29, 32'd1);
        wait_cnt(20);
        check("pre_status", st(), 32'h0);
        wr(5'd28, 32'd1);
        check("pass_status", st(), 32'hC);
        check("pass_tnum", test_num, 32'd5);
        check("pass_cyc", cycles, 32'd21);
        idle(100);
        check("pass_hold_cyc", cycles, 32'd21);
        check("pass_hold_st", st(), 32'hC);

        // Fail with x29=0, then post-terminal writes ignored.
        do_reset();
        wr(5'd3, 32'd7);
        wr(5'd29, 32'd0);
        wr(5'd28, 32'd1);
        check("fail_status", st(), 32'hA);
        check("fail_tnum", test_num, 32'd7);
        check("fail_cyc", cycles, 32'd3);
        wr(5'd3, 32'd9);
        wr(5'd28, 32'd1);
        check("fail_hold_tnum", test_num, 32'd7);
        check("fail_hold_st", st(), 32'hA);
        check("fail_hold_cyc", cycles, 32'd3);

        // Guard: x28=1 without any x29 write.
        do_reset();
        wr(5'd28, 32'd1);
        check("nox29_status", st(), 32'hA);

        // Guard: x0 write, x28!=1, x3 load.
        do_reset();
        wr(5'd0, 32'd1);
        wr(5'd28, 32'd2);
        wr(5'd3, 32'd4);
        check("guard_status", st(), 32'h0);
        check("guard_tnum", test_num, 32'd4);
        check("guard_cyc", cycles, 32'd3);

        // Timeout after the 50th edge.
        do_reset();
        idle(TO - 1);
        check("to_pre_st", st(), 32'h0);
        check("to_pre_cyc", cycles, TO - 1);
        idle(1);
        check("to_status", st(), 32'h9);
        check("to_cyc", cycles, TO);
        idle(5);
        check("to_hold_cyc", cycles, TO);

        // Trigger on the timeout edge wins.
        do_reset();
        wr(5'd29, 32'd1);
        wait_cnt(TO - 1);
        wr(5'd28, 32'd1);
        check("tie_status", st(), 32'hC);
        check("tie_cyc", cycles, TO);

        // Reset mid-run at cycle 30; write during reset ignored.
        do_reset();
        wr(5'd3, 32'd6);
        wait_cnt(30);
        rst      = 1'b1;
        rf_wen   = 1'b1;
        rf_waddr = 5'd3;
        rf_wdata = 32'd3;
        @(negedge clk);
        rst      = 1'b0;
        rf_wen   = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        check("mid_rst_st", st(), 32'h0);
        check("mid_rst_tnum", test_num, 32'd0);
        check("mid_rst_cyc", cycles, 32'd0);

        // Reach PASS, reset, then x28=1 alone must fail.
        wr(5'd29, 32'd1);
        wr(5'd28, 32'd1);
        check("p2_status", st(), 32'hC);
        do_reset();
        check("term_rst_st", st(), 32'h0);
        check("term_rst_cyc", cycles, 32'd0);
        wr(5'd28, 32'd1);
        check("shadow_clr_st", st(), 32'hA);
        check("shadow_clr_cyc", cycles, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
